// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/EXEC1/EXEC2/SHIFT/HALT control unit and opcode decoder for the accumulator CPU.
// Latency: strobes are combinational from the state register, IR, flags and shift counter. Instructions take 2 or 3 cycles, or 1+SHAMT cycles for shifts of 2 or more.
// Backpressure: MEM_READY low stalls FETCH, STA-EXEC1 and EXEC2 for one cycle each, and no strobe fires twice.
// Ports: CLK/RESET (sync, active-high); IR/SHAMT opcode and shift count; EQ/MI accumulator flags;
//        MEM_READY RAM handshake; RUN leaves HALT; FETCH..HALTED one-hot state; the rest are datapath strobes.
module control_sequencer #(
  parameter int SHW      = 4,
  parameter bit HAS_WAIT = 1'b1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [3:0]     IR,
  input  logic [SHW-1:0] SHAMT,
  input  logic           EQ,
  input  logic           MI,
  input  logic           MEM_READY,
  input  logic           RUN,
  output logic           FETCH,
  output logic           EXEC1,
  output logic           EXEC2,
  output logic           SHIFT,
  output logic           HALTED,
  output logic           IR_LOAD,
  output logic           EXTRA,
  output logic           Wren,
  output logic           MUX1,
  output logic           MUX3,
  output logic           MUX3_useAllBits,
  output logic           PC_sload,
  output logic           PC_cnt_en,
  output logic           ACC_EN,
  output logic           ACC_LOAD,
  output logic           ACC_SHIFTIN,
  output logic           ADDSUB
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_SHIFT = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           mem_rdy;
  logic           shift_in;

  // Without wait states the RAM is always considered ready.
  assign mem_rdy  = HAS_WAIT ? MEM_READY : 1'b1;
  // Arithmetic shift replicates the sign bit; logical shift fills with zero.
  assign shift_in = (IR == OP_ASR) & MI;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    FETCH           = 1'b0;
    EXEC1           = 1'b0;
    EXEC2           = 1'b0;
    SHIFT           = 1'b0;
    HALTED          = 1'b0;
    IR_LOAD         = 1'b0;
    EXTRA           = 1'b0;
    Wren            = 1'b0;
    MUX1            = 1'b0;
    MUX3            = 1'b0;
    MUX3_useAllBits = 1'b0;
    PC_sload        = 1'b0;
    PC_cnt_en       = 1'b0;
    ACC_EN          = 1'b0;
    ACC_LOAD        = 1'b0;
    ACC_SHIFTIN     = 1'b0;
    ADDSUB          = 1'b0;

    case (state_q)
      S_FETCH: begin
        FETCH   = 1'b1;
        IR_LOAD = mem_rdy;
        if (mem_rdy) state_d = S_EXEC1;
      end

      S_EXEC1: begin
        EXEC1   = 1'b1;
        state_d = S_FETCH;
        case (IR)
          OP_LDA, OP_ADD, OP_SUB: begin
            EXTRA   = 1'b1;
            MUX1    = 1'b1;
            state_d = S_EXEC2;
          end
          OP_STA: begin
            // Address and write enable are held until the RAM accepts the write.
            MUX1 = 1'b1;
            Wren = 1'b1;
            if (mem_rdy) PC_cnt_en = 1'b1;
            else         state_d   = S_EXEC1;
          end
          OP_JMP: PC_sload = 1'b1;
          OP_JMI: begin
            PC_sload  = MI;
            PC_cnt_en = ~MI;
          end
          OP_JEQ: begin
            PC_sload  = EQ;
            PC_cnt_en = ~EQ;
          end
          OP_LDI: begin
            MUX3      = 1'b1;
            ACC_EN    = 1'b1;
            ACC_LOAD  = 1'b1;
            PC_cnt_en = 1'b1;
          end
          OP_LSR, OP_ASR: begin
            if (SHAMT == '0) begin
              PC_cnt_en = 1'b1;
            end else begin
              // The first shift happens here, so SHIFT only covers the remaining SHAMT-1.
              ACC_EN          = 1'b1;
              MUX3_useAllBits = 1'b1;
              ACC_SHIFTIN     = shift_in;
              if (SHAMT == SHW'(1)) begin
                PC_cnt_en = 1'b1;
              end else begin
                cnt_d   = SHAMT - SHW'(1);
                state_d = S_SHIFT;
              end
            end
          end
          OP_STP: begin
            PC_cnt_en = 1'b1;
            state_d   = S_HALT;
          end
          default: PC_cnt_en = 1'b1;
        endcase
      end

      S_EXEC2: begin
        EXEC2 = 1'b1;
        if (!mem_rdy) begin
          MUX1 = 1'b1;
        end else begin
          ACC_EN          = 1'b1;
          ACC_LOAD        = 1'b1;
          PC_cnt_en       = 1'b1;
          ADDSUB          = (IR == OP_ADD);
          MUX3            = (IR == OP_LDA);
          MUX3_useAllBits = (IR == OP_LDA);
          state_d         = S_FETCH;
        end
      end

      S_SHIFT: begin
        SHIFT           = 1'b1;
        ACC_EN          = 1'b1;
        MUX3_useAllBits = 1'b1;
        ACC_SHIFTIN     = shift_in;
        cnt_d           = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          PC_cnt_en = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_HALT: begin
        HALTED = 1'b1;
        if (RUN) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised control unit for the accumulator CPU. It merges the FETCH/EXEC1/EXEC2 state machine and the opcode decoder into one block, and adds four features:
- multi-cycle shifts by an immediate count;
- memory wait-state handshake;
- STP halt with RUN restart;
- defined NOP behaviour for unused opcodes.

It drives the datapath strobes (PC, ACC, muxes, RAM write enable) directly from its own state register.

## Interface
Parameters:
- SHW, 4, width of the shift-count field and the internal shift counter; maximum shift is 2^SHW-1
- HAS_WAIT, 1, 1 = honour MEM_READY; 0 = MEM_READY is treated as constant 1

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- IR  input  4  opcode from the instruction register, stable from EXEC1 until the next FETCH
- SHAMT  input  SHW  shift count, the low operand bits of the instruction register
- EQ  input  1  ACC == 0 flag
- MI  input  1  ACC sign flag
- MEM_READY  input  1  RAM data valid / write accepted
- RUN  input  1  leave HALT
- FETCH, EXEC1, EXEC2, SHIFT, HALTED  output  1 each  one-hot state indicators
- IR_LOAD  output  1  load the instruction register
- EXTRA, Wren, MUX1, MUX3, MUX3_useAllBits  output  1 each  datapath strobes, same meaning as the existing datapath
- PC_sload, PC_cnt_en  output  1 each  PC load / PC increment
- ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB  output  1 each  accumulator control

## Operation
Opcodes:
- 0 LDA, 1 STA, 2 ADD, 3 SUB
- 4 JMP, 5 JMI, 6 JEQ, 7 STP
- 8 LDI, A LSR, B ASR
- 9, C–F: NOP

State machine: FETCH, EXEC1, EXEC2, SHIFT, HALT. Outputs are combinational from state, IR, flags and counter. Any strobe not listed for a state/opcode is 0.

FETCH:
- IR_LOAD = MEM_READY.
- Advance to EXEC1 when MEM_READY; otherwise stay.

EXEC1:
- LDA/ADD/SUB: EXTRA=1, MUX1=1 -> EXEC2.
- STA: MUX1=1, Wren=1.
  - If MEM_READY: PC_cnt_en=1 -> FETCH.
  - Else hold Wren/MUX1 and stay in EXEC1.
- JMP: PC_sload=1 -> FETCH.
- JMI: PC_sload=MI, PC_cnt_en=!MI -> FETCH.
- JEQ: PC_sload=EQ, PC_cnt_en=!EQ -> FETCH.
- LDI: MUX3=1, ACC_EN=1, ACC_LOAD=1, PC_cnt_en=1 -> FETCH.
- LSR/ASR with SHAMT=0: PC_cnt_en=1 -> FETCH; ACC untouched.
- LSR/ASR with SHAMT=1: one shift cycle (ACC_EN=1, MUX3_useAllBits=1, ACC_SHIFTIN=ASR&MI) plus PC_cnt_en=1 -> FETCH.
- LSR/ASR with SHAMT>=2: the same shift cycle; counter loads SHAMT-1 -> SHIFT.
- STP: PC_cnt_en=1 -> HALT.
- NOP opcodes: PC_cnt_en=1 -> FETCH.

EXEC2 (LDA/ADD/SUB only):
- MEM_READY=0: MUX1=1 holds the operand address; no ACC or PC strobes; stay.
- MEM_READY=1: ACC_EN=1, ACC_LOAD=1, PC_cnt_en=1, ADDSUB=ADD, MUX3=LDA, MUX3_useAllBits=LDA -> FETCH.

SHIFT:
- Each cycle: ACC_EN=1, MUX3_useAllBits=1, ACC_SHIFTIN=ASR&MI; counter decrements.
- When counter==1: PC_cnt_en=1 -> FETCH.

HALT:
- All strobes 0, HALTED=1.
- RUN=1 -> FETCH next cycle, resuming at the instruction after STP.

RESET=1 at any cycle:
- Next state FETCH, counter 0, regardless of current state.
- A shift or memory wait in progress is abandoned; no partial strobes are issued after the reset edge.

## Timing
- Reset values (state FETCH): FETCH=1; EXEC1, EXEC2, SHIFT, HALTED all 0; all strobes 0 except IR_LOAD=MEM_READY.
- Instruction length with zero wait states:
  - JMP, JMI, JEQ, STA, LDI, NOP: 2 cycles.
  - LDA, ADD, SUB: 3 cycles.
  - LSR/ASR: 2 cycles for SHAMT≤1, otherwise 1+SHAMT cycles.
  - STP: 2 cycles, then HALT.
- Each MEM_READY=0 cycle in FETCH, STA-EXEC1 or EXEC2 adds exactly one cycle; no strobe fires twice.
- Exactly one of PC_sload/PC_cnt_en pulses once per instruction (zero if reset intervenes). They are never high together.
- ACC_SHIFTIN is evaluated from MI in every shift cycle.
- RUN is ignored outside HALT. RUN held high while STP executes gives HALT for exactly one cycle.
- SHAMT is sampled only in EXEC1.

## Test plan
- Reset then LDA, MEM_READY=1: FETCH→EXEC1 (EXTRA=1, MUX1=1)→EXEC2 (ACC_LOAD=1, PC_cnt_en=1, MUX3=1)→FETCH; 3 cycles.
- ADD with MEM_READY low for 2 EXEC2 cycles: MUX1 held, no ACC_EN until the 3rd EXEC2 cycle; then ADDSUB=1; total 5 cycles.
- ASR SHAMT=5, MI=1: ACC_EN=1 and ACC_SHIFTIN=1 on 5 consecutive cycles; PC_cnt_en only on the last; 6 cycles total.
- LSR SHAMT=0, then LSR SHAMT=1: no ACC_EN / one ACC_EN pulse respectively; PC_cnt_en once each; 2 cycles each.
- JEQ EQ=0, then JEQ EQ=1, then JMI MI=1: PC_cnt_en, PC_sload, PC_sload respectively; never both.
- STP: HALTED=1 with all strobes 0 for 10 cycles; RUN=1 -> FETCH next cycle. RESET asserted in SHIFT with counter=3 -> FETCH next cycle, no further ACC_EN.
